// File: rtl/ov5640_cfg_seq.sv
// ov5640_cfg_seq: walks a {reg_addr,value} table and programs the OV5640 through the IIC core's dynamic-mode TX FIFO.
// Latency: each AXI op costs one issue cycle plus handshake cycles; an entry is 4 FIFO writes, >=1 status read, FETCH/DECODE/NEXT.
// Backpressure: every AXI valid is held until its own ready; POLL re-reads until the SCCB transfer drains.
// Build option OV5640_CFG_TIMEOUT_EN bounds POLL at POLL_MAX status reads per entry.
module ov5640_cfg_seq #(
    parameter logic [31:0] IIC_BASE = 32'h0,
    parameter logic [7:0]  DEV_ADDR = 8'h78,
    parameter int          TBL_AW   = 8,
    parameter int          TBL_LEN  = 256,
    parameter int          DLY_UNIT = 100000,
    parameter logic [19:0] POLL_MAX = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic [31:0]       m_axil_awaddr,
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,
    output logic [31:0]       m_axil_wdata,
    output logic [3:0]        m_axil_wstrb,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,
    input  logic [1:0]        m_axil_bresp,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,
    output logic [31:0]       m_axil_araddr,
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,
    input  logic [31:0]       m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready
);

    typedef logic [TBL_AW:0] idx_t;

    localparam logic [31:0] A_SRST = IIC_BASE + 32'h040;
    localparam logic [31:0] A_CR   = IIC_BASE + 32'h100;
    localparam logic [31:0] A_SR   = IIC_BASE + 32'h104;
    localparam logic [31:0] A_TX   = IIC_BASE + 32'h108;
    localparam logic [31:0] DLY_W  = 32'(DLY_UNIT);
    localparam idx_t        LAST   = idx_t'(TBL_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SRST, S_CREN, S_FETCH, S_DECODE, S_WSTA, S_WRHI,
        S_WRLO, S_WDAT, S_POLL, S_DELAY, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic              in_flight, in_flight_nx;
    idx_t              idx, idx_nx;
    logic [15:0]       ent_addr, ent_addr_nx;
    logic [7:0]        ent_val, ent_val_nx;
    logic [31:0]       dly_cnt, dly_cnt_nx;
    logic              done_nx, error_nx;
    logic [TBL_AW-1:0] err_idx_nx;
    logic [31:0]       awaddr_nx, wdata_nx, araddr_nx;
    logic [3:0]        wstrb_nx;
    logic              awvalid_nx, wvalid_nx, bready_nx, arvalid_nx, rready_nx;

    // Write states only pick address/data/successor; the shared engine below runs the handshake
    logic              is_wr;
    logic [31:0]       wr_addr, wr_data;
    state_t            wr_next;
    logic              sr_idle;

`ifdef OV5640_CFG_TIMEOUT_EN
    logic [19:0]       poll_cnt, poll_cnt_nx;
`else
    logic              unused_bits;
    assign unused_bits = ^{m_axil_rdata[31:8], m_axil_rdata[6:3], m_axil_rdata[1:0], POLL_MAX};
`endif

    assign busy     = (state != S_IDLE);
    assign tbl_addr = idx[TBL_AW-1:0];
    assign sr_idle  = m_axil_rdata[7] && !m_axil_rdata[2];

    always_comb begin
        state_nx     = state;
        in_flight_nx = in_flight;
        idx_nx       = idx;
        ent_addr_nx  = ent_addr;
        ent_val_nx   = ent_val;
        dly_cnt_nx   = dly_cnt;
        done_nx      = done;
        error_nx     = error;
        err_idx_nx   = err_idx;
        awaddr_nx    = m_axil_awaddr;
        wdata_nx     = m_axil_wdata;
        wstrb_nx     = m_axil_wstrb;
        araddr_nx    = m_axil_araddr;
        awvalid_nx   = m_axil_awvalid;
        wvalid_nx    = m_axil_wvalid;
        bready_nx    = m_axil_bready;
        arvalid_nx   = m_axil_arvalid;
        rready_nx    = m_axil_rready;
        is_wr        = 1'b0;
        wr_addr      = A_TX;
        wr_data      = 32'h0;
        wr_next      = state;
`ifdef OV5640_CFG_TIMEOUT_EN
        poll_cnt_nx  = poll_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SRST;
                    idx_nx   = '0;
                    done_nx  = 1'b0;
                    error_nx = 1'b0;
                end
            end
            S_SRST: begin
                is_wr   = 1'b1;
                wr_addr = A_SRST;
                wr_data = 32'h0000_000A;
                wr_next = S_CREN;
            end
            S_CREN: begin
                is_wr   = 1'b1;
                wr_addr = A_CR;
                wr_data = 32'h0000_0001;
                wr_next = S_FETCH;
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                ent_addr_nx = tbl_data[23:8];
                ent_val_nx  = tbl_data[7:0];
`ifdef OV5640_CFG_TIMEOUT_EN
                poll_cnt_nx = '0;
`endif
                if (tbl_data[23:8] == 16'hFFFF) begin
                    state_nx   = S_DELAY;
                    dly_cnt_nx = 32'(tbl_data[7:0]) * DLY_W;
                end else begin
                    state_nx   = S_WSTA;
                end
            end
            S_WSTA: begin
                is_wr   = 1'b1;
                wr_data = 32'h100 | {24'h0, DEV_ADDR};
                wr_next = S_WRHI;
            end
            S_WRHI: begin
                is_wr   = 1'b1;
                wr_data = {24'h0, ent_addr[15:8]};
                wr_next = S_WRLO;
            end
            S_WRLO: begin
                is_wr   = 1'b1;
                wr_data = {24'h0, ent_addr[7:0]};
                wr_next = S_WDAT;
            end
            S_WDAT: begin
                is_wr   = 1'b1;
                wr_data = 32'h200 | {24'h0, ent_val};
                wr_next = S_POLL;
            end
            S_POLL: begin
                if (!in_flight) begin
                    araddr_nx    = A_SR;
                    arvalid_nx   = 1'b1;
                    rready_nx    = 1'b1;
                    in_flight_nx = 1'b1;
                end else begin
                    if (m_axil_arvalid && m_axil_arready)
                        arvalid_nx = 1'b0;
                    if (m_axil_rready && m_axil_rvalid) begin
                        rready_nx    = 1'b0;
                        in_flight_nx = 1'b0;
                        if (m_axil_rresp != 2'b00)
                            state_nx = S_ERR;
                        else if (sr_idle)
                            state_nx = S_NEXT;
`ifdef OV5640_CFG_TIMEOUT_EN
                        else begin
                            poll_cnt_nx = poll_cnt + 20'd1;
                            if (poll_cnt + 20'd1 >= POLL_MAX)
                                state_nx = S_ERR;
                        end
`endif
                    end
                end
            end
            S_DELAY: begin
                // Loaded with value*DLY_UNIT, so the state lasts exactly that many cycles (min 1)
                if (dly_cnt <= 32'd1)
                    state_nx = S_NEXT;
                else
                    dly_cnt_nx = dly_cnt - 32'd1;
            end
            S_NEXT: begin
                if (idx == LAST) begin
                    state_nx = S_DONE;
                end else begin
                    idx_nx   = idx + idx_t'(1);
                    state_nx = S_FETCH;
                end
            end
            S_DONE: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                error_nx     = 1'b1;
                err_idx_nx   = idx[TBL_AW-1:0];
                in_flight_nx = 1'b0;
                awvalid_nx   = 1'b0;
                wvalid_nx    = 1'b0;
                bready_nx    = 1'b0;
                arvalid_nx   = 1'b0;
                rready_nx    = 1'b0;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (is_wr) begin
            if (!in_flight) begin
                awaddr_nx    = wr_addr;
                wdata_nx     = wr_data;
                wstrb_nx     = 4'hF;
                awvalid_nx   = 1'b1;
                wvalid_nx    = 1'b1;
                bready_nx    = 1'b1;
                in_flight_nx = 1'b1;
            end else begin
                if (m_axil_awvalid && m_axil_awready)
                    awvalid_nx = 1'b0;
                if (m_axil_wvalid && m_axil_wready)
                    wvalid_nx = 1'b0;
                if (m_axil_bready && m_axil_bvalid) begin
                    bready_nx    = 1'b0;
                    in_flight_nx = 1'b0;
                    state_nx     = (m_axil_bresp != 2'b00) ? S_ERR : wr_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            in_flight      <= 1'b0;
            idx            <= '0;
            ent_addr       <= '0;
            ent_val        <= '0;
            dly_cnt        <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_idx        <= '0;
            m_axil_awaddr  <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_araddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            state          <= state_nx;
            in_flight      <= in_flight_nx;
            idx            <= idx_nx;
            ent_addr       <= ent_addr_nx;
            ent_val        <= ent_val_nx;
            dly_cnt        <= dly_cnt_nx;
            done           <= done_nx;
            error          <= error_nx;
            err_idx        <= err_idx_nx;
            m_axil_awaddr  <= awaddr_nx;
            m_axil_wdata   <= wdata_nx;
            m_axil_wstrb   <= wstrb_nx;
            m_axil_araddr  <= araddr_nx;
            m_axil_awvalid <= awvalid_nx;
            m_axil_wvalid  <= wvalid_nx;
            m_axil_bready  <= bready_nx;
            m_axil_arvalid <= arvalid_nx;
            m_axil_rready  <= rready_nx;
        end
    end

`ifdef OV5640_CFG_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            poll_cnt <= '0;
        else
            poll_cnt <= poll_cnt_nx;
    end
`endif

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: behavioural AXI-lite slave plus an entry-level model of the expected FIFO write stream.
`timescale 1ns/1ps
module tb_ov5640_cfg_seq;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [7:0]  DEV    = 8'h78;
    localparam int          AW     = 2;
    localparam int          LEN    = 4;
    localparam int          DLY    = 10;
    localparam logic [19:0] PMAX   = 20'd4;
    localparam logic [31:0] A_SRST = BASE + 32'h040;
    localparam logic [31:0] A_CR   = BASE + 32'h100;
    localparam logic [31:0] A_SR   = BASE + 32'h104;
    localparam logic [31:0] A_TX   = BASE + 32'h108;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, error;
    logic [AW-1:0] err_idx, tbl_addr;
    logic [23:0] tbl_data = '0;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    ov5640_cfg_seq #(
        .IIC_BASE(BASE), .DEV_ADDR(DEV), .TBL_AW(AW), .TBL_LEN(LEN),
        .DLY_UNIT(DLY), .POLL_MAX(PMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .error(error), .err_idx(err_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // Synchronous table ROM
    logic [23:0] rom [LEN];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    logic [63:0] got_q[$], exp_q[$];
    int gap_q[$];
    int n_vec = 0, n_mis = 0;
    int exp_reads = 0, gap_norm = 0;
    int cyc = 0, n_rd = 0, n_bhs = 0, n_awhs = 0, n_whs = 0, n_arhs = 0;
    int bad_ar = 0, bad_strb = 0;
    int aw_dly = 0, w_dly = 0, cur_aw = 0, cur_w = 0;
    bit rand_dly = 0;
    int busy_reads = 0, sr_left = 0, err_wr = -1, wr_num = 0;
    int aw_hi = 0, w_hi = 0, max_aw_hi = 0, max_w_hi = 0, aw_start = 0, last_r = 0;
    int aw_wait = 0, w_wait = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0;
    logic [31:0] cap_a = '0, cap_d = '0;

    // AXI-lite slave: decides its outputs on the falling edge for the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0;
                rdata = 0; rresp = 0; aw_got = 0; w_got = 0; ar_got = 0;
                aw_wait = 0; w_wait = 0; aw_hi = 0; w_hi = 0;
            end else begin
                bvalid = aw_got && w_got;
                bresp  = (bvalid && wr_num == err_wr) ? 2'b10 : 2'b00;
                rvalid = ar_got;
                rdata  = (sr_left > 0) ? 32'h04 : 32'h80;
                rresp  = 2'b00;
                awready = 0;
                if (awvalid) begin
                    if (aw_hi == 0) aw_start = cyc;
                    aw_hi++;
                    if (!aw_got) begin
                        if (aw_wait >= cur_aw) begin
                            awready = 1; aw_got = 1; cap_a = awaddr; n_awhs++;
                        end else aw_wait++;
                    end
                end
                wready = 0;
                if (wvalid) begin
                    w_hi++;
                    if (!w_got) begin
                        if (w_wait >= cur_w) begin
                            wready = 1; w_got = 1; cap_d = wdata; n_whs++;
                            if (wstrb != 4'hF) bad_strb++;
                        end else w_wait++;
                    end
                end
                arready = 0;
                if (arvalid && !ar_got) begin
                    arready = 1; ar_got = 1; n_arhs++;
                    if (araddr != A_SR) bad_ar++;
                end
                if (bvalid && bready) begin
                    got_q.push_back({cap_a, cap_d});
                    gap_q.push_back(aw_start - last_r);
                    if (cap_d[9:8] == 2'b10) sr_left = busy_reads;
                    n_bhs++; wr_num++;
                    aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
                    if (aw_hi > max_aw_hi) max_aw_hi = aw_hi;
                    if (w_hi > max_w_hi) max_w_hi = w_hi;
                    aw_hi = 0; w_hi = 0;
                    if (rand_dly) begin
                        cur_aw = $urandom_range(0, 3); cur_w = $urandom_range(0, 3);
                    end else begin
                        cur_aw = aw_dly; cur_w = w_dly;
                    end
                end
                if (rvalid && rready) begin
                    n_rd++; ar_got = 0; last_r = cyc;
                    if (sr_left > 0) sr_left--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < LEN; i++)
            rom[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom_range(0, 255))};
    endtask

    // Reference: two setup writes, then four FIFO writes and (busy_reads+1) SR reads per register entry
    task automatic build_exp();
        logic [15:0] ra;
        logic [7:0]  v;
        exp_q = {};
        exp_reads = 0;
        exp_q.push_back({A_SRST, 32'hA});
        exp_q.push_back({A_CR, 32'h1});
        for (int i = 0; i < LEN; i++) begin
            ra = rom[i][23:8];
            v  = rom[i][7:0];
            if (ra != 16'hFFFF) begin
                exp_q.push_back({A_TX, 32'h100 + 32'(DEV)});
                exp_q.push_back({A_TX, 32'(ra / 256)});
                exp_q.push_back({A_TX, 32'(ra % 256)});
                exp_q.push_back({A_TX, 32'h200 + 32'(v)});
                exp_reads += busy_reads + 1;
            end
        end
    endtask

    task automatic clr_sb();
        got_q = {}; gap_q = {};
        n_rd = 0; n_bhs = 0; n_awhs = 0; n_whs = 0; n_arhs = 0; wr_num = 0;
        bad_ar = 0; bad_strb = 0; max_aw_hi = 0; max_w_hi = 0; sr_left = 0;
        cur_aw = aw_dly; cur_w = w_dly;
    endtask

    task automatic run_seq(input string tag, input bit poke);
        int c = 0;
        clr_sb();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        while (busy && c < 6000) begin
            start = (poke && c == 30);
            @(negedge clk);
            c++;
        end
        start = 0;
        chk({tag, "_in_budget"}, c < 6000, 1);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_nrd"}, n_rd, exp_reads);
        chk({tag, "_bhs"}, n_bhs, exp_q.size());
        chk({tag, "_awhs"}, n_awhs, exp_q.size());
        chk({tag, "_whs"}, n_whs, exp_q.size());
        chk({tag, "_araddr"}, bad_ar, 0);
        chk({tag, "_wstrb"}, bad_strb, 0);
    endtask

    initial begin
        int c;
        int wr_at_rst;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid}, 0);
        chk("rst_readies", {bready, rready}, 0);
        chk("rst_wstrb", wstrb, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // A: fixed first two entries, ideal slave, stray start mid-run
        fill_rom();
        rom[0] = 24'h3008_82;
        rom[1] = 24'h3103_11;
        aw_dly = 0; w_dly = 0; rand_dly = 0; busy_reads = 0; err_wr = -1;
        build_exp();
        run_seq("A", 1);
        cmp_log("A");
        chk("A_done", done, 1);
        chk("A_error", error, 0);
        chk("A_busy", busy, 0);
        gap_norm = (gap_q.size() > 6) ? gap_q[6] : -1000;

        // B: awready 3 cycles late, wready immediate
        fill_rom();
        aw_dly = 3; w_dly = 0;
        build_exp();
        run_seq("B", 0);
        cmp_log("B");
        chk("B_awvalid_cycles", max_aw_hi, 4);
        chk("B_wvalid_cycles", max_w_hi, 1);
        chk("B_done", done, 1);

        // R: random ready delays and random busy polls
        fill_rom();
        aw_dly = 0; w_dly = 0; rand_dly = 1;
        busy_reads = $urandom_range(0, 3);
        build_exp();
        run_seq("R", 0);
        cmp_log("R");
        chk("R_done", done, 1);
        rand_dly = 0;

        // C: SR busy for 5 reads per entry
        fill_rom();
        busy_reads = 5;
        build_exp();
        run_seq("C", 0);
        cmp_log("C");
        chk("C_reads_total", n_rd, 24);
        busy_reads = 0;

        // D: delay entry mid-table, zero delay as the last entry
        fill_rom();
        rom[1] = 24'hFFFF_02;
        rom[3] = 24'hFFFF_00;
        build_exp();
        run_seq("D", 0);
        cmp_log("D");
        chk("D_reads", n_rd, 2);
        c = (gap_q.size() > 6) ? gap_q[6] - gap_norm : -1;
        chk("D_delay_gap", (c >= 20 && c <= 24), 1);
        chk("D_done", done, 1);

        // E: bresp error on WRLO of entry 3
        fill_rom();
        err_wr = 16;
        run_seq("E", 0);
        chk("E_error", error, 1);
        chk("E_done", done, 0);
        chk("E_err_idx", err_idx, 3);
        chk("E_busy", busy, 0);
        chk("E_bhs", n_bhs, 17);
        chk("E_reads", n_rd, 3);
        repeat (40) @(negedge clk);
        chk("E_quiet_aw", n_awhs, 17);
        chk("E_quiet_ar", n_arhs, 3);
        err_wr = -1;

        // F: error clears on restart; reset during WDAT; then full restart
        fill_rom();
        clr_sb();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        chk("F_err_clr", error, 0);
        chk("F_busy", busy, 1);
        c = 0;
        while (got_q.size() < 5 && c < 2000) begin @(negedge clk); c++; end
        chk("F_reach_wdat", c < 2000, 1);
        @(negedge clk);
        rst_n = 0;
        wr_at_rst = got_q.size();
        @(negedge clk);
        chk("F_rst_busy", busy, 0);
        chk("F_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("F_rst_idx", tbl_addr, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("F_wr_before_rst", wr_at_rst, 5);
        chk("F_no_stray", got_q.size(), 5);
        build_exp();
        run_seq("F", 0);
        cmp_log("F");
        chk("F_done", done, 1);
        chk("F_error", error, 0);

`ifdef OV5640_CFG_TIMEOUT_EN
        // G: SR stuck busy, bounded by POLL_MAX reads
        fill_rom();
        busy_reads = 50;
        run_seq("G", 0);
        chk("G_error", error, 1);
        chk("G_err_idx", err_idx, 0);
        chk("G_reads", n_rd, 32'(PMAX));
        chk("G_bhs", n_bhs, 6);
        busy_reads = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
